// File: rtl/score_keeper_pkg.sv
// Shared game definitions: match state encoding, default geometry/timing
// constants and winner codes, used by the score keeper and ball controller.
package score_keeper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CENTRE,
    WAIT_SERVE,
    PLAY,
    SCORED,
    OVER
  } game_state_t;

  localparam int unsigned GAME_WIN_SCORE    = 9;
  localparam int unsigned GAME_SERVE_FRAMES = 60;
  localparam int unsigned GAME_X_LEFT_EXIT  = 6;
  localparam int unsigned GAME_X_RIGHT_EXIT = 1017;
  localparam int unsigned GAME_X_CENTRE     = 504;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Add one point, never passing the winning score.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/score_keeper_frame_counter.sv
// Frame counter for the serve delay: counts end_of_frame ticks from a clear
// and flags the tick that brings the count to TERMINAL.
module score_keeper_frame_counter
  import score_keeper_pkg::*;
#(
  parameter int unsigned TERMINAL = GAME_SERVE_FRAMES
) (
  input  logic clk65MHz,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TERMINAL - 1);

  logic [7:0] count;

  // Count frames since the last clear, holding at the top value.
  always_ff @(posedge clk65MHz) begin
    if (!rst || clr) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + 8'd1;
    end
  end

  // Flag is raised on the tick that completes the count, so the consumer
  // can act on the same edge the count reaches TERMINAL.
  assign tc = tick && !clr && (count == LAST);

endmodule

// File: rtl/score_keeper.sv
// Match score keeper: sequences centre / serve / play / score, counts points
// per side, and declares the winner when a side reaches WIN_SCORE.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = GAME_WIN_SCORE,
  parameter int unsigned SERVE_FRAMES = GAME_SERVE_FRAMES,
  parameter int unsigned X_LEFT_EXIT  = GAME_X_LEFT_EXIT,
  parameter int unsigned X_RIGHT_EXIT = GAME_X_RIGHT_EXIT,
  parameter int unsigned X_CENTRE     = GAME_X_CENTRE
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        end_of_frame,
  input  logic        screen_idle,
  input  logic        screen_multi,
  input  logic [10:0] x_pos_of_ball,
  output logic        serve,
  output logic [3:0]  points_player_1,
  output logic [3:0]  points_player_2,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [3:0]  WIN = 4'(WIN_SCORE);
  localparam logic [10:0] XL  = 11'(X_LEFT_EXIT);
  localparam logic [10:0] XR  = 11'(X_RIGHT_EXIT);
  localparam logic [10:0] XC  = 11'(X_CENTRE);

  game_state_t state;
  logic [1:0]  scorer;
  logic        serve_due;
  logic        cnt_clr;
  logic        exit_right;
  logic        exit_left;

  // The serve delay only runs while waiting to serve.
  assign cnt_clr    = (state != WAIT_SERVE) || screen_idle;
  assign exit_right = (x_pos_of_ball >= XR);
  assign exit_left  = (x_pos_of_ball <= XL);

  score_keeper_frame_counter #(
    .TERMINAL (SERVE_FRAMES)
  ) u_frame_counter (
    .clk65MHz (clk65MHz),
    .rst      (rst),
    .clr      (cnt_clr),
    .tick     (end_of_frame),
    .tc       (serve_due)
  );

  // Match sequencing with registered outputs; idle screen overrides everything.
  always_ff @(posedge clk65MHz) begin
    if (!rst) begin
      state           <= IDLE;
      serve           <= 1'b0;
      points_player_1 <= '0;
      points_player_2 <= '0;
      game_over       <= 1'b0;
      winner          <= WINNER_NONE;
      scorer          <= WINNER_NONE;
    end else if (screen_idle) begin
      state           <= IDLE;
      serve           <= 1'b0;
      points_player_1 <= '0;
      points_player_2 <= '0;
      game_over       <= 1'b0;
      winner          <= WINNER_NONE;
      scorer          <= WINNER_NONE;
    end else begin
      serve <= 1'b0;
      case (state)
        IDLE: begin
          points_player_1 <= '0;
          points_player_2 <= '0;
          game_over       <= 1'b0;
          winner          <= WINNER_NONE;
          scorer          <= WINNER_NONE;
          state           <= CENTRE;
        end
        CENTRE: begin
          if (x_pos_of_ball == XC) state <= WAIT_SERVE;
        end
        WAIT_SERVE: begin
          if (serve_due) begin
            serve <= 1'b1;
            state <= PLAY;
          end
        end
        PLAY: begin
          if (end_of_frame) begin
            if (screen_multi) begin
              // Right exit is checked first so it wins if the exits overlap.
              if (exit_right) begin
                points_player_2 <= sat_inc(points_player_2, WIN);
                scorer          <= WINNER_P2;
                state           <= SCORED;
              end else if (exit_left) begin
                points_player_1 <= sat_inc(points_player_1, WIN);
                scorer          <= WINNER_P1;
                state           <= SCORED;
              end
            end else if (exit_right || exit_left) begin
              points_player_2 <= sat_inc(points_player_2, WIN);
              scorer          <= WINNER_P2;
              state           <= SCORED;
            end
          end
        end
        SCORED: begin
          if (((scorer == WINNER_P1) ? points_player_1 : points_player_2) == WIN) begin
            game_over <= 1'b1;
            winner    <= scorer;
            state     <= OVER;
          end else begin
            state <= CENTRE;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: expected output snapshots are queued
// as stimulus is driven and compared whenever the DUT outputs change.
module tb_score_keeper;
  import score_keeper_pkg::*;

  logic        clk65MHz = 1'b0;
  logic        rst;
  logic        end_of_frame;
  logic        screen_idle;
  logic        screen_multi;
  logic [10:0] x_pos_of_ball;
  logic        serve;
  logic [3:0]  points_player_1;
  logic [3:0]  points_player_2;
  logic        game_over;
  logic [1:0]  winner;

  score_keeper #(
    .SERVE_FRAMES (3)
  ) dut (
    .clk65MHz        (clk65MHz),
    .rst             (rst),
    .end_of_frame    (end_of_frame),
    .screen_idle     (screen_idle),
    .screen_multi    (screen_multi),
    .x_pos_of_ball   (x_pos_of_ball),
    .serve           (serve),
    .points_player_1 (points_player_1),
    .points_player_2 (points_player_2),
    .game_over       (game_over),
    .winner          (winner)
  );

  always #5 clk65MHz = ~clk65MHz;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Snapshot layout: {serve, p1[3:0], p2[3:0], game_over, winner[1:0]}
  string       tag_q[$];
  logic [11:0] val_q[$];
  logic [11:0] model_snap;
  logic [11:0] prev_snap;
  logic [11:0] mon_snap;
  logic [11:0] exp_val;
  string       exp_tag;
  bit          mon_en = 1'b0;

  function automatic logic [11:0] snap();
    return {serve, points_player_1, points_player_2, game_over, winner};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_snap(input string tag, input logic s, input logic [3:0] p1,
                             input logic [3:0] p2, input logic go, input logic [1:0] w);
    model_snap = {s, p1, p2, go, w};
    tag_q.push_back(tag);
    val_q.push_back(model_snap);
  endtask

  // Compare every output change against the next queued expectation.
  always @(negedge clk65MHz) begin
    if (mon_en) begin
      mon_snap = snap();
      if (mon_snap !== prev_snap) begin
        if (val_q.size() > 0) begin
          exp_tag = tag_q.pop_front();
          exp_val = val_q.pop_front();
          check_val(exp_tag, 32'(mon_snap), 32'(exp_val));
        end else begin
          check_val("spurious_change", 32'(mon_snap), 32'(model_snap));
        end
        prev_snap = mon_snap;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk65MHz);
    #1;
  endtask

  task automatic frame(input logic [10:0] x);
    x_pos_of_ball = x;
    end_of_frame  = 1'b1;
    tick(1);
    end_of_frame  = 1'b0;
  endtask

  // From CENTRE: recentre the ball, run the serve delay, land in PLAY.
  task automatic serve_up();
    logic [11:0] m;
    x_pos_of_ball = 11'd504;
    tick(1);
    m = model_snap;
    expect_snap("serve_rise", 1'b1, m[10:7], m[6:3], m[2], m[1:0]);
    expect_snap("serve_fall", 1'b0, m[10:7], m[6:3], m[2], m[1:0]);
    frame(11'd504);
    frame(11'd504);
    check_val("serve_early", 32'(serve), 32'd0);
    frame(11'd504);
    check_val("serve_pulse", 32'(serve), 32'd1);
    check_val("state_play", 32'(dut.state), 32'(PLAY));
    tick(1);
    check_val("serve_one_cycle", 32'(serve), 32'd0);
  endtask

  // From PLAY: near-miss frames, then nfr exit frames; ends back in CENTRE.
  task automatic play_out(input logic [10:0] xe, input int unsigned nfr,
                          input logic [3:0] e1, input logic [3:0] e2);
    frame(11'd7);
    frame(11'd1016);
    expect_snap("score", 1'b0, e1, e2, 1'b0, WINNER_NONE);
    repeat (nfr) frame(xe);
    tick(1);
  endtask

  task automatic rally(input logic [10:0] xe, input logic [3:0] e1, input logic [3:0] e2);
    serve_up();
    play_out(xe, 1, e1, e2);
  endtask

  task automatic check_drained(input string tag);
    tick(2);
    check_val(tag, 32'(val_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    screen_idle   = 1'b1;
    screen_multi  = 1'b1;
    end_of_frame  = 1'b0;
    x_pos_of_ball = 11'd504;
    tick(3);
    check_val("rst_serve", 32'(serve), 32'd0);
    check_val("rst_p1", 32'(points_player_1), 32'd0);
    check_val("rst_p2", 32'(points_player_2), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    check_val("rst_winner", 32'(winner), 32'd0);
    rst = 1'b1;
    tick(1);
    check_val("rst_state", 32'(dut.state), 32'(IDLE));
    model_snap = '0;
    prev_snap  = snap();
    mon_en     = 1'b1;

    // Release idle, serve after three frames, then a held right exit scores once.
    screen_idle = 1'b0;
    tick(1);
    serve_up();
    play_out(11'd1018, 5, 4'd0, 4'd1);
    check_drained("drain_first_point");

    // Player 1 climbs to 8 on the left exit boundary, then wins.
    for (int i = 1; i <= 8; i++) begin
      rally((i % 2 == 1) ? 11'd5 : 11'd6, 4'(i), 4'd1);
    end
    serve_up();
    expect_snap("win_score", 1'b0, 4'd9, 4'd1, 1'b0, WINNER_NONE);
    expect_snap("win_over", 1'b0, 4'd9, 4'd1, 1'b1, WINNER_P1);
    frame(11'd5);
    tick(1);
    check_val("over_game_over", 32'(game_over), 32'd1);
    check_val("over_winner", 32'(winner), 32'(WINNER_P1));
    repeat (5) frame(11'd504);
    check_val("over_state", 32'(dut.state), 32'(OVER));
    check_drained("drain_over");

    // Idle clears the match; single player credits both exits to player 2.
    expect_snap("idle_clear", 1'b0, 4'd0, 4'd0, 1'b0, WINNER_NONE);
    screen_idle = 1'b1;
    tick(1);
    screen_idle  = 1'b0;
    screen_multi = 1'b0;
    tick(1);
    rally(11'd3, 4'd0, 4'd1);
    rally(11'd1020, 4'd0, 4'd2);
    check_val("single_p1", 32'(points_player_1), 32'd0);
    check_val("single_p2", 32'(points_player_2), 32'd2);
    check_drained("drain_single");

    // Idle on the same edge as an exit frame: no point, everything cleared.
    serve_up();
    frame(11'd7);
    expect_snap("idle_abort", 1'b0, 4'd0, 4'd0, 1'b0, WINNER_NONE);
    screen_idle = 1'b1;
    frame(11'd6);
    check_val("idle_abort_state", 32'(dut.state), 32'(IDLE));
    screen_idle  = 1'b0;
    screen_multi = 1'b1;
    tick(1);
    check_drained("drain_idle_abort");

    // Reset part-way through the serve count, then a full clean sequence.
    rally(11'd1017, 4'd0, 4'd1);
    x_pos_of_ball = 11'd504;
    tick(1);
    frame(11'd504);
    frame(11'd504);
    expect_snap("rst_clear", 1'b0, 4'd0, 4'd0, 1'b0, WINNER_NONE);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check_val("rst_mid_state", 32'(dut.state), 32'(IDLE));
    check_val("rst_mid_serve", 32'(serve), 32'd0);
    tick(1);
    serve_up();
    play_out(11'd1018, 1, 4'd0, 4'd1);
    check_drained("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9, points needed to win a match (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frames between ball re-centring and serve pulse (1..255).
REQ-003 Parameter X_LEFT_EXIT, default 6, ball x at or below which the left player has missed.
REQ-004 Parameter X_RIGHT_EXIT, default 1017, ball x at or above which the right player has missed.
REQ-005 Parameter X_CENTRE, default 504, ball x indicating re-centred (start) position.
REQ-006 clk65MHz  input  1  sole clock; all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 end_of_frame  input  1  one-cycle pulse per video frame.
REQ-009 screen_idle  input  1  menu/idle screen active.
REQ-010 screen_multi  input  1  1 = two-player match, 0 = single-player.
REQ-011 x_pos_of_ball  input  11  current ball x from the ball controller.
REQ-012 serve  output  1  one-cycle pulse releasing the ball controller from START.
REQ-013 points_player_1  output  4  right-side player score.
REQ-014 points_player_2  output  4  left-side (or CPU) player score.
REQ-015 game_over  output  1  match finished, held high.
REQ-016 winner  output  2  00 none, 01 player 1, 10 player 2; 11 never driven.

Function
REQ-017 FSM states SHALL be IDLE, CENTRE, WAIT_SERVE, PLAY, SCORED, OVER.
REQ-018 IDLE: scores, frame counter, game_over, winner cleared; leave to CENTRE on first cycle screen_idle=0.
REQ-019 CENTRE: go to WAIT_SERVE when x_pos_of_ball == X_CENTRE; frame counter cleared on entry.
REQ-020 WAIT_SERVE: counter increments on each end_of_frame; when it reaches SERVE_FRAMES, serve=1 for exactly that one cycle and state becomes PLAY next cycle.
REQ-021 PLAY: ball x sampled only on cycles with end_of_frame=1.
REQ-022 PLAY, multi: x >= X_RIGHT_EXIT -> points_player_2 +1; x <= X_LEFT_EXIT -> points_player_1 +1; then SCORED.
REQ-023 PLAY, single: either exit condition -> points_player_2 +1; then SCORED.
REQ-024 Exactly one point per exit event; no further increment until PLAY is re-entered.
REQ-025 Score update and state change occur on the same edge, one cycle after the sampled end_of_frame.
REQ-026 SCORED: if the updated score equals WIN_SCORE -> OVER; else -> CENTRE.
REQ-027 Scores SHALL saturate at WIN_SCORE; 4-bit wrap-around is forbidden.
REQ-028 OVER: game_over=1, winner set to the side that reached WIN_SCORE; serve held 0; remains until screen_idle=1.
REQ-029 screen_idle=1 in any state forces IDLE on the next edge; takes priority over simultaneous end_of_frame, exit, or serve count completion (no serve pulse, no increment).
REQ-030 screen_multi change mid-match only affects subsequent exit evaluations; scores unchanged.
REQ-031 serve SHALL be registered and never asserted outside the WAIT_SERVE->PLAY transition cycle.
REQ-032 Both exit conditions true simultaneously is impossible for legal parameters; if X_LEFT_EXIT >= X_RIGHT_EXIT, the right-exit rule takes precedence.

Reset
REQ-033 On rst=0 at a clock edge: state IDLE, serve 0, both scores 0, game_over 0, winner 00, frame counter 0.
REQ-034 Reset mid-serve-count or mid-SCORED aborts the operation with no serve pulse and no score change.

Structure
REQ-035 State enum and default constants (WIN_SCORE, SERVE_FRAMES, exit/centre x values) SHALL live in the shared game package, reused by the ball controller.
REQ-036 One sub-module, frame_counter (end_of_frame-driven 8-bit counter with clear and terminal-count flag), SHALL implement the serve delay.

Verification
REQ-037 Release screen_idle, x=504, SERVE_FRAMES=3 -> serve pulses one cycle after the 3rd end_of_frame; state PLAY.
REQ-038 Multi, PLAY, x=1018 with end_of_frame held at x for 5 frames -> points_player_2 increments 0->1 exactly once.
REQ-039 Multi, points_player_1=8, x=5 on end_of_frame -> points_player_1=9, game_over=1, winner=01, no further serve.
REQ-040 Single, x=3 then x=1020 in separate rallies -> points_player_2=2, points_player_1=0.
REQ-041 screen_idle=1 on same cycle as exit-sample end_of_frame -> no increment, state IDLE, all outputs cleared.
REQ-042 rst=0 during WAIT_SERVE at count 2 of 3 -> all outputs reset values, no serve pulse before the next full sequence.
